sccb_responder: RTL

SCCB (I2C-compatible) slave that implements the camera end of the configuration link: it decodes the 3-phase write and 2-phase read transactions produced by our SCCB master and holds the resulting camera register image. It sits on the `sioc`/`siod` pins in place of (or alongside) a real OV7670 for bring-up and closed-loop verification of the camera configuration path. All pin activity is oversampled on the system clock; the block has no second clock domain.

---
 rtl/sccb_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sccb_responder.sv
// SCCB slave emulating the camera end of the config link.
// Oversamples sioc/siod on clk and holds a 256-entry register image.
module sccb_responder #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, SUB, SUB_ACK,
        DATA, DATA_ACK, RD, RD_ACK, IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl, sda, scl_q, sda_q;
    logic       scl_rise, scl_fall, start, stop;
    logic [3:0] bit_cnt;
    logic [7:0] shreg, sub_ptr, rd_cur, rd_inc;
    logic       nack, wr_pend, oe_nxt;
    logic       id_match, seen, byte_end, rx_state;
    logic [7:0] regfile [256];

    // Synchronizers idle high so reset looks like a released bus
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], sioc};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], siod_in};
            scl_q    <= scl;
            sda_q    <= sda;
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

    assign id_match = shreg[7:1] == DEV_ID[7:1];
    assign seen     = bit_cnt != 4'd0;
    assign byte_end = bit_cnt == 4'd8;
    assign rx_state = state inside {DEV, SUB, DATA};
    assign rd_cur   = regfile[sub_ptr];
    assign rd_inc   = regfile[sub_ptr + 8'd1];
    assign rd_data  = regfile[rd_addr];
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = DEV;
        end else if (scl_fall) begin
            unique case (state)
                DEV:      if (byte_end) state_nxt = id_match ? DEV_ACK : IGNORE;
                SUB:      if (byte_end) state_nxt = SUB_ACK;
                DATA:     if (byte_end) state_nxt = DATA_ACK;
                RD:       if (byte_end) state_nxt = RD_ACK;
                DEV_ACK:  if (seen) state_nxt = shreg[0] ? RD : SUB;
                SUB_ACK:  if (seen) state_nxt = DATA;
                DATA_ACK: if (seen) state_nxt = DATA;
                RD_ACK:   if (seen) state_nxt = nack ? IGNORE : RD;
                default:  state_nxt = state;
            endcase
        end
    end

    // Pin drive only moves on a sioc falling edge (or START/STOP release)
    always_comb begin
        oe_nxt = siod_oe;
        if (start || stop) begin
            oe_nxt = 1'b0;
        end else if (scl_fall) begin
            unique case (state)
                DEV:      if (byte_end) oe_nxt = id_match;
                SUB:      if (byte_end) oe_nxt = 1'b1;
                DATA:     if (byte_end) oe_nxt = 1'b1;
                DEV_ACK:  if (seen) oe_nxt = shreg[0] & ~rd_cur[7];
                SUB_ACK:  if (seen) oe_nxt = 1'b0;
                DATA_ACK: if (seen) oe_nxt = 1'b0;
                RD:       if (seen) oe_nxt = byte_end ? 1'b0 : ~shreg[6];
                RD_ACK:   if (seen) oe_nxt = ~nack & ~rd_inc[7];
                default:  oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            sub_ptr  <= '0;
            nack     <= 1'b0;
            wr_pend  <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            siod_oe  <= 1'b0;
        end else begin
            siod_oe  <= oe_nxt;
            wr_pend  <= 1'b0;
            wr_valid <= wr_pend;
            if (wr_pend) begin
                wr_addr <= sub_ptr;
                wr_data <= shreg;
            end
            if (start || stop || state_nxt != state)
                bit_cnt <= '0;
            else if (scl_rise && !byte_end)
                bit_cnt <= bit_cnt + 4'd1;
            if (!start && !stop) begin
                if (rx_state && scl_rise && !byte_end) begin
                    shreg <= {shreg[6:0], sda};
                    if (bit_cnt == 4'd7 && state == SUB)
                        sub_ptr <= {shreg[6:0], sda};
                    if (bit_cnt == 4'd7 && state == DATA)
                        wr_pend <= 1'b1;
                end
                if (state == RD && scl_fall && seen && !byte_end)
                    shreg <= {shreg[6:0], 1'b0};
                if (state == RD_ACK && scl_rise)
                    nack <= sda;
                if (state == DEV_ACK && state_nxt == RD)
                    shreg <= rd_cur;
                if (state == RD_ACK && state_nxt == RD) begin
                    shreg   <= rd_inc;
                    sub_ptr <= sub_ptr + 8'd1;
                end
                if (state == DATA_ACK && state_nxt == DATA)
                    sub_ptr <= sub_ptr + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 256; i++) regfile[i] <= '0;
        end else if (wr_pend) begin
            regfile[sub_ptr] <= shreg;
        end
    end

endmodule
